// File: rtl/ftdi_frame_packer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ftdi_pkg
//  Description : Shared definitions for the FTDI frame packer: the FSM state
//                encoding and the default frame-header byte.
//  Revision    : 1.0 - initial release
// ============================================================================
package ftdi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // waiting for a frame to start
    ST_PACK  = 2'd1,  // packing bytes into words
    ST_FLUSH = 2'd2,  // last word of the frame being written
    ST_DONE  = 2'd3   // frame_full pulse
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage : ftdi_pkg
`default_nettype wire

// File: rtl/ftdi_frame_packer_byte_shift_packer.sv
`default_nettype none
// ============================================================================
//  Module      : byte_shift_packer
//  Description : Shifts accepted bytes MSB-first into a DATA_WIDTH-bit word
//                and counts bytes within the word. word_valid is asserted
//                combinationally during the cycle the final byte of a word is
//                accepted, with the completed word on 'word', so the owner can
//                register it on the same edge.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                byte_in       - byte to pack
//                byte_en       - byte_in is accepted on this edge
//                word_valid    - this byte completes a word
//                word          - completed word (valid with word_valid)
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_shift_packer #(
  parameter int DATA_WIDTH = 80
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            byte_in,
  input  logic                  byte_en,
  output logic                  word_valid,
  output logic [DATA_WIDTH-1:0] word
);

  localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
  localparam int CNT_W          = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);

  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    if (byte_en) begin
      byte_cnt_d = (byte_cnt_q == LAST_BYTE) ? '0 : byte_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_q <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
    end
  end

  assign word_valid = byte_en && (byte_cnt_q == LAST_BYTE);

  generate
    if (BYTES_PER_WORD > 1) begin : g_multi
      // Only the leading BYTES_PER_WORD-1 bytes need storage; the final byte
      // is taken straight from byte_in when the word completes. Leftover bytes
      // from the previous word are fully shifted out before the next
      // word_valid, so no clear is needed between words.
      logic [DATA_WIDTH-9:0] part_q, part_d;

      assign word = {part_q, byte_in};

      always_comb begin
        part_d = part_q;
        if (byte_en) begin
          part_d = word[DATA_WIDTH-9:0];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          part_q <= '0;
        end else begin
          part_q <= part_d;
        end
      end
    end else begin : g_single
      assign word = byte_in;
    end
  endgenerate

endmodule : byte_shift_packer
`default_nettype wire

// File: rtl/ftdi_frame_packer.sv
`default_nettype none
// ============================================================================
//  Module      : ftdi_frame_packer
//  Description : Accepts the host byte stream from the FTDI receive FIFO,
//                packs DATA_WIDTH/8 bytes (MSB first) into each framebuffer
//                word, writes WORDS_PER_FRAME words per frame and pulses
//                frame_full once the last word of a frame has been written.
//                'hold' only blocks the start of a new frame.
//  Config      : FRAME_SYNC_EN - when defined, a frame starts only after the
//                header byte SYNC_BYTE; all other bytes seen while idle are
//                consumed and dropped, and the header itself is not stored.
//  Ports       : sys_clk, sys_rst         - clock, sync active-high reset
//                rx_data, rx_valid        - byte stream from the FTDI FIFO
//                rx_ready                 - byte accepted when valid & ready
//                hold                     - strips busy, no new frame start
//                fb_wdata, fb_waddr, fb_we- framebuffer write port
//                frame_full               - one-cycle end-of-frame pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module ftdi_frame_packer
  import ftdi_pkg::*;
#(
  parameter int         DATA_WIDTH      = 80,
  parameter int         ADDR_WIDTH      = 8,
  parameter int         WORDS_PER_FRAME = 256,
  parameter logic [7:0] SYNC_BYTE       = SYNC_BYTE_DEFAULT
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  input  logic                  hold,
  output logic [DATA_WIDTH-1:0] fb_wdata,
  output logic [ADDR_WIDTH-1:0] fb_waddr,
  output logic                  fb_we,
  output logic                  frame_full
);

`ifdef FRAME_SYNC_EN
  localparam logic SYNC_EN = 1'b1;
`else
  localparam logic SYNC_EN = 1'b0;
`endif

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORDS_PER_FRAME - 1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   word_cnt_q, word_cnt_d;
  logic                    rx_ready_q, rx_ready_d;
  logic                    fb_we_q, fb_we_d;
  logic                    frame_full_q, frame_full_d;
  logic [DATA_WIDTH-1:0]   fb_wdata_q, fb_wdata_d;
  logic [ADDR_WIDTH-1:0]   fb_waddr_q, fb_waddr_d;

  logic                    accept;
  logic                    pack_en;
  logic                    word_valid;
  logic [DATA_WIDTH-1:0]   word;

  assign accept = rx_valid & rx_ready_q;

  byte_shift_packer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_packer (
    .clk        (sys_clk),
    .rst        (sys_rst),
    .byte_in    (rx_data),
    .byte_en    (pack_en),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    fb_we_d    = 1'b0;
    fb_wdata_d = fb_wdata_q;
    fb_waddr_d = fb_waddr_q;
    pack_en    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          // Without a header the first byte is already pixel data; with a
          // header only SYNC_BYTE opens the frame and is itself dropped.
          pack_en = ~SYNC_EN;
          if (~SYNC_EN | (rx_data == SYNC_BYTE)) begin
            state_d = ST_PACK;
          end
        end
      end
      ST_PACK:  pack_en = accept;
      ST_FLUSH: state_d = ST_DONE;
      ST_DONE: begin
        word_cnt_d = '0;
        state_d    = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase

    // A completed word is written on the next cycle; the last word of the
    // frame moves the FSM to FLUSH, covering the case where that word
    // completes straight out of IDLE.
    if (word_valid) begin
      fb_we_d    = 1'b1;
      fb_wdata_d = word;
      fb_waddr_d = word_cnt_q;
      if (word_cnt_q == LAST_ADDR) begin
        word_cnt_d = '0;
        state_d    = ST_FLUSH;
      end else begin
        word_cnt_d = word_cnt_q + ADDR_WIDTH'(1);
      end
    end

    // Outputs are registered, so they are derived from the next state.
    frame_full_d = (state_d == ST_DONE);
    case (state_d)
      ST_IDLE: rx_ready_d = ~hold;
      ST_PACK: rx_ready_d = 1'b1;
      default: rx_ready_d = 1'b0;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= ST_IDLE;
      word_cnt_q   <= '0;
      rx_ready_q   <= 1'b0;
      fb_we_q      <= 1'b0;
      frame_full_q <= 1'b0;
      fb_wdata_q   <= '0;
      fb_waddr_q   <= '0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      rx_ready_q   <= rx_ready_d;
      fb_we_q      <= fb_we_d;
      frame_full_q <= frame_full_d;
      fb_wdata_q   <= fb_wdata_d;
      fb_waddr_q   <= fb_waddr_d;
    end
  end

  assign rx_ready   = rx_ready_q;
  assign fb_we      = fb_we_q;
  assign frame_full = frame_full_q;
  assign fb_wdata   = fb_wdata_q;
  assign fb_waddr   = fb_waddr_q;

endmodule : ftdi_frame_packer
`default_nettype wire

// File: tb/tb_ftdi_frame_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ftdi_frame_packer
//  Description : Self-checking bench for ftdi_frame_packer. A byte-level
//                reference model turns the accepted byte stream into the
//                expected framebuffer writes, frame_full pulses and rx_ready
//                level, and is compared against the DUT every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ftdi_frame_packer;

  localparam int DW          = 80;
  localparam int AW          = 8;
  localparam int WPF         = 256;
  localparam int BPW         = DW / 8;
  localparam int FRAME_BYTES = WPF * BPW;

  logic          sys_clk  = 1'b0;
  logic          sys_rst  = 1'b1;
  logic [7:0]    rx_data  = 8'h00;
  logic          rx_valid = 1'b0;
  logic          hold     = 1'b0;
  logic          rx_ready;
  logic [DW-1:0] fb_wdata;
  logic [AW-1:0] fb_waddr;
  logic          fb_we;
  logic          frame_full;

  always #5 sys_clk = ~sys_clk;

  ftdi_frame_packer #(
    .DATA_WIDTH      (DW),
    .ADDR_WIDTH      (AW),
    .WORDS_PER_FRAME (WPF),
    .SYNC_BYTE       (8'hA5)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .hold       (hold),
    .fb_wdata   (fb_wdata),
    .fb_waddr   (fb_waddr),
    .fb_we      (fb_we),
    .frame_full (frame_full)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 = idle (rx_ready follows !hold of previous edge), 1 = in frame
  // (rx_ready high), 2 = forced-low window after reset / frame end.
  int            phase    = 2;
  int            gap_left = 1;
  int            nbytes   = 0;
  logic [7:0]    wbuf [BPW];
  bit            armed    = 1'b0;
  bit            exp_we   = 1'b0;
  bit            exp_ff   = 1'b0;
  bit            ff_pend  = 1'b0;
  bit            exp_zero = 1'b0;
  logic [DW-1:0] exp_data = '0;
  logic [AW-1:0] exp_addr = '0;
  logic          hold_prev = 1'b0;

  int            we_cnt = 0;
  int            ff_cnt = 0;
  logic [DW-1:0] cap  [WPF];
  logic [DW-1:0] snap [WPF];

  task automatic model_store(input logic [7:0] b);
    wbuf[nbytes % BPW] = b;
    nbytes++;
    if (nbytes % BPW == 0) begin
      exp_we = 1'b1;
      for (int k = 0; k < BPW; k++) exp_data[DW-1-8*k -: 8] = wbuf[k];
      exp_addr = AW'(nbytes / BPW - 1);
      if (nbytes == FRAME_BYTES) begin
        ff_pend  = 1'b1;
        nbytes   = 0;
        phase    = 2;
        gap_left = 2;
      end
    end
  endtask

  always @(negedge sys_clk) begin
    if (armed) begin
      chk("fb_we", fb_we, exp_we);
      chk("frame_full", frame_full, exp_ff);
      if (exp_we) begin
        chk("fb_wdata", fb_wdata, exp_data);
        chk("fb_waddr", fb_waddr, exp_addr);
      end
      if (exp_zero) begin
        chk("rst_wdata", fb_wdata, 0);
        chk("rst_waddr", fb_waddr, 0);
      end
      case (phase)
        1:       chk("rx_ready_frame", rx_ready, 1);
        2:       chk("rx_ready_low", rx_ready, 0);
        default: chk("rx_ready_idle", rx_ready, !hold_prev);
      endcase
      if (fb_we) begin
        we_cnt++;
        cap[fb_waddr] = fb_wdata;
      end
      if (frame_full) ff_cnt++;
    end
    if (phase == 2) begin
      gap_left--;
      if (gap_left <= 0) phase = 0;
    end
    exp_we   = 1'b0;
    exp_ff   = ff_pend;
    ff_pend  = 1'b0;
    exp_zero = 1'b0;
    if (sys_rst) begin
      armed    = 1'b1;
      phase    = 2;
      gap_left = 1;
      nbytes   = 0;
      exp_ff   = 1'b0;
      exp_zero = 1'b1;
    end else if (armed && rx_valid && rx_ready) begin
      if (phase == 0) begin
`ifdef FRAME_SYNC_EN
        if (rx_data == 8'hA5) phase = 1;
`else
        phase = 1;
        model_store(rx_data);
`endif
      end else begin
        model_store(rx_data);
      end
    end
    hold_prev = hold;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit acc;
    acc      = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge sys_clk);
      acc = rx_ready;
      @(posedge sys_clk);
      #1;
    end
    if (!acc) chk("send_byte_timeout", acc, 1);
  endtask

  // mode 0: b[i] = i[7:0]; mode 1: random bytes. gap_pct: chance of an
  // idle rx_valid gap before each byte. hold_last raises hold with the last byte.
  task automatic send_stream(input int mode, input int gap_pct, input int count, input bit hold_last);
    logic [7:0] b;
    for (int i = 0; i < count; i++) begin
      b = (mode == 0) ? i[7:0] : 8'($urandom);
      if ($urandom_range(99) < gap_pct) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        repeat ($urandom_range(1, 3)) tick();
      end
      if (hold_last && i == count - 1) hold = 1'b1;
      send_byte(b);
    end
  endtask

  task automatic clear_counts();
    we_cnt = 0;
    ff_cnt = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rx_ready"}, rx_ready, 0);
    chk({tag, "_fb_we"}, fb_we, 0);
    chk({tag, "_frame_full"}, frame_full, 0);
    chk({tag, "_fb_waddr"}, fb_waddr, 0);
    chk({tag, "_fb_wdata"}, fb_wdata, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    sys_rst = 1'b1;
    repeat (3) tick();
    chk_reset_outputs("reset");
    sys_rst = 1'b0;

    // 1: continuous incrementing stream, latency of the final word/pulse
    clear_counts();
    send_stream(0, 0, FRAME_BYTES, 1'b0);
    rx_valid = 1'b0;
    chk("t1_last_we", fb_we, 1);
    chk("t1_ff_not_yet", frame_full, 0);
    tick();
    chk("t1_ff_pulse", frame_full, 1);
    tick();
    chk("t1_ff_single", frame_full, 0);
    repeat (3) tick();
    chk("t1_we_count", we_cnt, 256);
    chk("t1_ff_count", ff_cnt, 1);
    chk("t1_addr0", cap[0], 80'h00010203040506070809);
    chk("t1_addr255", cap[255], 80'hF6F7F8F9FAFBFCFDFEFF);
    for (int a = 0; a < WPF; a++) snap[a] = cap[a];

    // 2: same stream with 50% random rx_valid gaps
    clear_counts();
    for (int a = 0; a < WPF; a++) cap[a] = '0;
    send_stream(0, 50, FRAME_BYTES, 1'b0);
    rx_valid = 1'b0;
    repeat (5) tick();
    chk("t2_we_count", we_cnt, 256);
    chk("t2_ff_count", ff_cnt, 1);
    for (int a = 0; a < WPF; a++) chk("t2_mem_match", cap[a], snap[a]);

    // 3: hold blocks frame start; hold rising with frame completion
    clear_counts();
    hold = 1'b1;
    repeat (2) tick();
    rx_valid = 1'b1;
    rx_data  = 8'h3C;
    repeat (10) begin
      tick();
      chk("t3_hold_ready", rx_ready, 0);
    end
    chk("t3_hold_no_we", we_cnt, 0);
    hold = 1'b0;
    send_stream(1, 10, FRAME_BYTES, 1'b1);
    rx_data = 8'h5A;
    repeat (8) tick();
    chk("t3_ff_count", ff_cnt, 1);
    chk("t3_we_count", we_cnt, 256);
    chk("t3_hold_after_frame", rx_ready, 0);
    rx_valid = 1'b0;
    hold     = 1'b0;
    repeat (2) tick();

    // 4: reset after 1234 bytes, then a clean frame
    clear_counts();
    send_stream(0, 0, 1234, 1'b0);
    rx_valid = 1'b0;
    sys_rst  = 1'b1;
    tick();
    chk_reset_outputs("t4_midrst");
    sys_rst = 1'b0;
    clear_counts();
    send_stream(0, 0, FRAME_BYTES, 1'b0);
    rx_valid = 1'b0;
    repeat (5) tick();
    chk("t4_we_count", we_cnt, 256);
    chk("t4_ff_count", ff_cnt, 1);
    chk("t4_addr0", cap[0], 80'h00010203040506070809);
    chk("t4_addr123", cap[123], 80'hCECFD0D1D2D3D4D5D6D7);

`ifdef FRAME_SYNC_EN
    // 5: leading junk then header, header not stored
    clear_counts();
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'hA5);
    chk("t5_no_we_before_data", we_cnt, 0);
    send_stream(0, 0, FRAME_BYTES, 1'b0);
    rx_valid = 1'b0;
    repeat (5) tick();
    chk("t5_we_count", we_cnt, 256);
    chk("t5_ff_count", ff_cnt, 1);
    chk("t5_addr0", cap[0], 80'h00010203040506070809);
`else
    // 5: random bytes with gaps; every write is compared by the model
    clear_counts();
    send_stream(1, 30, FRAME_BYTES, 1'b0);
    rx_valid = 1'b0;
    repeat (5) tick();
    chk("t5_we_count", we_cnt, 256);
    chk("t5_ff_count", ff_cnt, 1);
`endif

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_ftdi_frame_packer
`default_nettype wire
